// File: rtl/axi_pkg.sv
// Shared encodings for the AXI4 read responder: burst/resp codes, beat size and FSM states.
package axi_pkg;

    localparam int unsigned DATA_W  = 128;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_16B    = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } rd_state_e;

endpackage

// File: rtl/axi_ar_fifo.sv
// Two-entry FIFO holding accepted AR requests until the read engine picks them up.
module axi_ar_fifo #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rest,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] slot [2];
    logic         wptr;
    logic         rptr;
    logic [1:0]   count;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) slot[wptr] <= wdata;
    end

    assign rdata = slot[rptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/axi_rd_slave.sv
// AXI4 read-channel responder serving 128-bit bursts from an internal word memory.
module axi_rd_slave
    import axi_pkg::*;
#(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned LEN_W     = 6,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                         clk,
    input  logic                         rest,
    input  logic                         arvalid,
    output logic                         arready,
    input  logic [ID_W-1:0]              arid,
    input  logic [31:0]                  araddr,
    input  logic [LEN_W-1:0]             arlen,
    input  logic [2:0]                   arsize,
    input  logic [1:0]                   arburst,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [ID_W-1:0]              rid,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_W-1:0]            mem_wdata
);

    localparam int unsigned AW     = $clog2(MEM_DEPTH);
    localparam int unsigned WCNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam int unsigned AR_W   = ID_W + ADDR_W + LEN_W + 3 + 2;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              push, pop, fifo_full, fifo_empty;
    logic [AR_W-1:0]   ar_head;
    logic [ID_W-1:0]   h_id;
    logic [31:0]       h_addr;
    logic [LEN_W-1:0]  h_len;
    logic [2:0]        h_size;
    logic [1:0]        h_burst;

    rd_state_e         state, state_d;
    logic [WCNT_W-1:0] wcnt, wcnt_d;
    logic [ID_W-1:0]   bid, bid_d;
    logic [31:0]       base, base_d;
    logic [LEN_W-1:0]  blen, blen_d, beat, beat_d;
    logic [2:0]        bsize, bsize_d;
    logic [1:0]        bburst, bburst_d;
    logic              rvalid_d, rlast_d;
    logic [ID_W-1:0]   rid_d;
    logic [DATA_W-1:0] rdata_d;
    logic [1:0]        rresp_d;
    logic              load, ld_ok;
    logic [31:0]       ld_idx;

    assign arready = ~fifo_full & ~rest;
    assign push    = arvalid & arready;
    assign {h_id, h_addr, h_len, h_size, h_burst} = ar_head;

    axi_ar_fifo #(.W(AR_W)) u_ar_fifo (
        .clk   (clk),
        .rest  (rest),
        .push  (push),
        .pop   (pop),
        .wdata ({arid, araddr, arlen, arsize, arburst}),
        .rdata (ar_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state  <= ST_IDLE;
            wcnt   <= '0;
            bid    <= '0;
            base   <= '0;
            blen   <= '0;
            beat   <= '0;
            bsize  <= '0;
            bburst <= '0;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            rid    <= '0;
            rdata  <= '0;
            rresp  <= '0;
        end else begin
            state  <= state_d;
            wcnt   <= wcnt_d;
            bid    <= bid_d;
            base   <= base_d;
            blen   <= blen_d;
            beat   <= beat_d;
            bsize  <= bsize_d;
            bburst <= bburst_d;
            rvalid <= rvalid_d;
            rlast  <= rlast_d;
            rid    <= rid_d;
            rdata  <= rdata_d;
            rresp  <= rresp_d;
        end
    end

    always_comb begin
        state_d  = state;
        wcnt_d   = wcnt;
        bid_d    = bid;
        base_d   = base;
        blen_d   = blen;
        beat_d   = beat;
        bsize_d  = bsize;
        bburst_d = bburst;
        rvalid_d = rvalid;
        rlast_d  = rlast;
        rid_d    = rid;
        rdata_d  = rdata;
        rresp_d  = rresp;
        pop      = 1'b0;
        load     = 1'b0;
        ld_idx   = base;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    bid_d    = h_id;
                    base_d   = h_addr >> 4;
                    blen_d   = h_len;
                    bsize_d  = h_size;
                    bburst_d = h_burst;
                    wcnt_d   = WCNT_W'(RD_LAT);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt == '0) begin
                    load     = 1'b1;
                    beat_d   = '0;
                    rvalid_d = 1'b1;
                    rid_d    = bid;
                    rlast_d  = (blen == '0);
                    state_d  = ST_BURST;
                end else begin
                    wcnt_d = wcnt - WCNT_W'(1);
                end
            end
            ST_BURST: begin
                if (rvalid && rready) begin
                    if (rlast) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        load    = 1'b1;
                        beat_d  = beat + LEN_W'(1);
                        rlast_d = ((beat + LEN_W'(1)) == blen);
                        if (bburst == BURST_INCR) ld_idx = base + 32'(beat) + 32'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Legality is judged per beat so INCR bursts can run off the end of memory.
        ld_ok = (ld_idx < 32'(MEM_DEPTH)) && (bsize == SIZE_16B) &&
                ((bburst == BURST_INCR) || (bburst == BURST_FIXED));
        if (load) begin
            rresp_d = ld_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_d = ld_ok ? mem[ld_idx[AW-1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_axi_rd_slave.sv
// Self-checking bench for axi_rd_slave: table vectors, corner sequences and random traffic vs a burst model.
module tb_axi_rd_slave;

    localparam int unsigned ID_W      = 4;
    localparam int unsigned LEN_W     = 6;
    localparam int unsigned MEM_DEPTH = 1024;
    localparam int unsigned RD_LAT    = 2;
    localparam int          LAT       = 2 + RD_LAT;

    logic             clk;
    logic             rest;
    logic             arvalid, arready;
    logic [ID_W-1:0]  arid;
    logic [31:0]      araddr;
    logic [LEN_W-1:0] arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             rvalid, rready;
    logic [ID_W-1:0]  rid;
    logic [127:0]     rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             mem_we;
    logic [9:0]       mem_waddr;
    logic [127:0]     mem_wdata;

    axi_rd_slave #(
        .ID_W(ID_W), .LEN_W(LEN_W), .MEM_DEPTH(MEM_DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rest(rest),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   id;
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [5:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          exp_beats;
        int          exp_ok;
    } vec_t;

    logic [127:0] ref_mem [MEM_DEPTH];
    beat_t        exp_q [$];
    int           errors = 0;
    int           checks = 0;
    int           acc_beats = 0;
    int           acc_ok = 0;
    bit           ar_done = 0;
    bit           stall_pend = 0;
    beat_t        stall_beat;
    bit           gap_active = 0;
    int           gap_cnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected beats of one accepted request, straight from the addressing/response rules.
    task automatic model_push(input logic [3:0] id, input logic [31:0] addr, input logic [5:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        for (int k = 0; k <= int'(len); k++) begin
            longint unsigned idx;
            bit    ok;
            beat_t b;
            idx = {32'd0, addr} >> 4;
            if (burst != 2'b00) idx += longint'(k);
            ok = (idx < MEM_DEPTH) && (burst == 2'b00 || burst == 2'b01) && (size == 3'd4);
            b.id   = id;
            b.data = ok ? ref_mem[int'(idx)] : 128'd0;
            b.resp = ok ? 2'b00 : 2'b10;
            b.last = (k == int'(len));
            exp_q.push_back(b);
        end
    endtask

    // Called at a falling edge with inputs set; handshakes seen now commit at the next rising edge.
    task automatic tick();
        beat_t got;
        got = '{id: rid, data: rdata, resp: rresp, last: rlast};
        ar_done = 0;
        if (arvalid && arready) begin
            model_push(arid, araddr, arlen, arsize, arburst);
            ar_done = 1;
        end
        if (gap_active) begin
            if (rvalid) begin
                chk("b2b_gap", 128'(gap_cnt), 128'(LAT));
                gap_active = 0;
            end else gap_cnt++;
        end
        if (stall_pend) begin
            checks++;
            if (!rvalid || got != stall_beat) begin
                errors++;
                $display("FAIL r_stable: rvalid=%0b got id=%0h resp=%0h last=%0b data=%0h held id=%0h resp=%0h last=%0b data=%0h",
                         rvalid, got.id, got.resp, got.last, got.data,
                         stall_beat.id, stall_beat.resp, stall_beat.last, stall_beat.data);
            end
        end
        stall_pend = 0;
        if (rvalid && rready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL r_unexpected: id=%0h resp=%0h data=%0h", got.id, got.resp, got.data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (got != e) begin
                    errors++;
                    $display("FAIL r_beat: got id=%0h resp=%0h last=%0b data=%0h expected id=%0h resp=%0h last=%0b data=%0h",
                             got.id, got.resp, got.last, got.data, e.id, e.resp, e.last, e.data);
                end
                if (got.last && exp_q.size() != 0) begin
                    gap_active = 1;
                    gap_cnt    = 0;
                end
            end
            acc_beats++;
            if (got.resp == 2'b00) acc_ok++;
        end else if (rvalid) begin
            stall_pend = 1;
            stall_beat = got;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [5:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        while (!arready && n < 300) begin
            tick();
            n++;
        end
        if (arready) tick();
        else begin
            checks++;
            errors++;
            $display("FAIL ar_accept: timed out after %0d cycles, required acceptance", n);
        end
        arvalid = 1'b0;
    endtask

    task automatic drain(input int max, input bit rnd);
        int n = 0;
        while ((exp_q.size() != 0 || rvalid) && n < max) begin
            rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        chk("drain_left", 128'(exp_q.size()), 128'd0);
        rready = 1'b1;
    endtask

    vec_t vecs [10];

    initial begin
        int n, ba, bo, rv, hs, remaining;

        vecs[0] = '{4'd5,  32'h0000_0000, 6'd3,  3'd4, 2'b01, 4,  4};
        vecs[1] = '{4'd1,  32'h0000_0020, 6'd2,  3'd4, 2'b00, 3,  3};
        vecs[2] = '{4'd2,  32'h0000_3FE0, 6'd3,  3'd4, 2'b01, 4,  2};
        vecs[3] = '{4'd3,  32'h0000_0010, 6'd1,  3'd4, 2'b10, 2,  0};
        vecs[4] = '{4'd4,  32'h0000_0010, 6'd0,  3'd4, 2'b11, 1,  0};
        vecs[5] = '{4'd6,  32'h0000_0040, 6'd2,  3'd3, 2'b01, 3,  0};
        vecs[6] = '{4'd7,  32'h0000_3FFF, 6'd1,  3'd4, 2'b01, 2,  1};
        vecs[7] = '{4'd8,  32'h0000_0013, 6'd0,  3'd4, 2'b01, 1,  1};
        vecs[8] = '{4'd9,  32'h0000_4000, 6'd0,  3'd4, 2'b00, 1,  0};
        vecs[9] = '{4'd15, 32'h0000_0100, 6'd63, 3'd4, 2'b01, 64, 64};

        rest = 1'b1; arvalid = 1'b0; rready = 1'b0; mem_we = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        mem_waddr = '0; mem_wdata = '0;
        @(negedge clk);
        tick();
        chk("rst_arready", 128'(arready), 128'd0);
        chk("rst_rvalid", 128'(rvalid), 128'd0);
        chk("rst_rlast", 128'(rlast), 128'd0);
        chk("rst_rid", 128'(rid), 128'd0);
        chk("rst_rdata", rdata, 128'd0);
        chk("rst_rresp", 128'(rresp), 128'd0);
        rest = 1'b0;
        tick();
        chk("arready_after_rst", 128'(arready), 128'd1);

        // Preload every word so each read has defined data.
        mem_we = 1'b1;
        for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            mem_waddr = 10'(i);
            if (i < 4) mem_wdata = {96'h0123_4567_89AB_CDEF_FEDC_BA98, 32'hA0 + 32'(i)};
            else       mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            ref_mem[i] = mem_wdata;
            tick();
        end
        mem_we = 1'b0;

        // First-beat latency on a simple INCR burst.
        rready = 1'b1;
        ba = acc_beats; bo = acc_ok;
        send_ar(4'd5, 32'h0, 6'd3, 3'd4, 2'b01);
        n = 0;
        while (!rvalid && n < 50) begin
            tick();
            n++;
        end
        chk("first_latency", 128'(n), 128'(LAT));
        chk("first_rdata_a0", rdata, {96'h0123_4567_89AB_CDEF_FEDC_BA98, 32'hA0});
        drain(100, 0);
        chk("incr4_beats", 128'(acc_beats - ba), 128'd4);
        chk("incr4_ok", 128'(acc_ok - bo), 128'd4);

        for (int v = 0; v < 10; v++) begin
            ba = acc_beats; bo = acc_ok;
            send_ar(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
            drain(300, 0);
            chk($sformatf("vec%0d_beats", v), 128'(acc_beats - ba), 128'(vecs[v].exp_beats));
            chk($sformatf("vec%0d_ok", v), 128'(acc_ok - bo), 128'(vecs[v].exp_ok));
        end

        // Stalled R channel: burst registers plus two FIFO entries, then arready must stay low.
        rready = 1'b0;
        send_ar(4'd10, 32'h0000_0400, 6'd1, 3'd4, 2'b01);
        send_ar(4'd11, 32'h0000_0800, 6'd2, 3'd4, 2'b01);
        send_ar(4'd12, 32'h0000_0C00, 6'd0, 3'd4, 2'b00);
        chk("arready_full", 128'(arready), 128'd0);
        arid = 4'd13; araddr = 32'h0000_1000; arlen = 6'd3; arsize = 3'd4; arburst = 2'b01;
        arvalid = 1'b1;
        hs = 0;
        repeat (8) begin
            tick();
            if (ar_done) hs++;
        end
        chk("ar_blocked", 128'(hs), 128'd0);
        rready = 1'b1;
        n = 0;
        while (!ar_done && n < 100) begin
            tick();
            n++;
        end
        chk("ar4_accepted", 128'(ar_done), 128'd1);
        arvalid = 1'b0;
        drain(200, 0);

        // Random backpressure on an 8-beat burst.
        ba = acc_beats;
        send_ar(4'd3, 32'h0000_1230, 6'd7, 3'd4, 2'b01);
        drain(400, 1);
        chk("bp8_beats", 128'(acc_beats - ba), 128'd8);

        // Reset while beat 2 of 8 is on the bus.
        rready = 1'b1;
        ba = acc_beats;
        send_ar(4'd10, 32'h0000_0200, 6'd7, 3'd4, 2'b01);
        n = 0;
        while ((acc_beats - ba) < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("pre_rst_rvalid", 128'(rvalid), 128'd1);
        rest = 1'b1;
        #1;
        chk("mid_rst_rvalid", 128'(rvalid), 128'd0);
        chk("mid_rst_rdata", rdata, 128'd0);
        chk("mid_rst_rid_last_resp", {rid, rlast, rresp}, 128'd0);
        chk("mid_rst_arready", 128'(arready), 128'd0);
        exp_q.delete();
        stall_pend = 0;
        gap_active = 0;
        @(negedge clk);
        tick();
        rest = 1'b0;
        tick();
        chk("post_rst_arready", 128'(arready), 128'd1);
        rv = 0;
        repeat (12) begin
            if (rvalid) rv++;
            tick();
        end
        chk("no_residual", 128'(rv), 128'd0);

        // Memory survives reset.
        ba = acc_beats; bo = acc_ok;
        send_ar(4'd5, 32'h0, 6'd3, 3'd4, 2'b01);
        drain(100, 0);
        chk("post_rst_ok", 128'(acc_ok - bo), 128'd4);

        // Random traffic against the model.
        remaining = 40;
        n = 0;
        while ((remaining > 0 || arvalid) && n < 4000) begin
            if (!arvalid && remaining > 0 && $urandom_range(0, 2) == 0) begin
                int b;
                b = int'($urandom_range(0, 9));
                arid    = 4'($urandom);
                arlen   = 6'($urandom_range(0, 15));
                arburst = (b < 4) ? 2'b01 : (b < 8) ? 2'b00 : (b == 8) ? 2'b10 : 2'b11;
                arsize  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd4;
                if ($urandom_range(0, 9) == 0) araddr = $urandom;
                else araddr = {18'd0, 10'($urandom_range(0, MEM_DEPTH - 1)), 4'($urandom)};
                arvalid = 1'b1;
            end
            rready = 1'($urandom_range(0, 1));
            tick();
            if (ar_done) begin
                arvalid = 1'b0;
                remaining--;
            end
            n++;
        end
        chk("rand_ar_issued", 128'(remaining), 128'd0);
        drain(3000, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
